control_sequencer: RTL and testbench

//  Hard-wired control unit driving the CPU datapath strobes (PCout, MARin, Zin, Read, Gra/Rin ...).

---
 rtl/control_sequencer_pkg.sv | 61 ++++++
 rtl/control_sequencer_if.sv | 37 +++
 rtl/control_sequencer_decode.sv | 34 +++
 rtl/control_sequencer.sv | 137 +++++++++++++
 tb/tb_control_sequencer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// ============================================================================
// cpu_ctrl_pkg: opcodes, instruction classes, sequencer states, step indices
// and the datapath strobe bundle shared by the control sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam int OP_W   = 5;
    localparam int STEP_W = 3;

    localparam logic [OP_W-1:0] OP_LD   = 5'd0;
    localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OP_W-1:0] OP_ST   = 5'd2;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OP_W-1:0] OP_AND  = 5'd5;
    localparam logic [OP_W-1:0] OP_OR   = 5'd6;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd9;
    localparam logic [OP_W-1:0] OP_SHRA = 5'd10;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd11;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
    localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
    localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd15;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd16;
    localparam logic [OP_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OP_W-1:0] OP_HALT = 5'd27;

    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_IMM, C_LD, C_ST, C_MULDIV, C_HALT
    } iclass_t;

    typedef enum logic [1:0] {
        S_RST, S_RUN, S_HALT
    } state_t;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;
    localparam logic [STEP_W-1:0] T5 = 3'd5;
    localparam logic [STEP_W-1:0] T6 = 3'd6;
    localparam logic [STEP_W-1:0] T7 = 3'd7;

    typedef struct packed {
        logic PCout;   logic Zhighout; logic Zlowout; logic MDRout; logic Cout;
        logic MARin;   logic PCin;     logic MDRin;   logic IRin;   logic Yin;
        logic Zin;     logic HIin;     logic LOin;    logic IncPC;
        logic Read;    logic Write;
        logic Gra;     logic Grb;      logic Grc;     logic Rin;    logic Rout;
        logic BAout;
    } strobes_t;

endpackage

`default_nettype wire

// File: rtl/control_sequencer_if.sv
// ============================================================================
// control_sequencer_if: IR/handshake inputs and strobe outputs between the
// control sequencer (master) and the datapath (slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
    logic        run;
    logic PCout, Zhighout, Zlowout, MDRout, Cout;
    logic MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC;
    logic Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout;

    modport master (
        input  ir, mem_ready, stop,
        output run,
        output PCout, Zhighout, Zlowout, MDRout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC,
        output Read, Write,
        output Gra, Grb, Grc, Rin, Rout, BAout
    );

    modport slave (
        output ir, mem_ready, stop,
        input  run,
        input  PCout, Zhighout, Zlowout, MDRout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC,
        input  Read, Write,
        input  Gra, Grb, Grc, Rin, Rout, BAout
    );
endinterface

`default_nettype wire

// File: rtl/control_sequencer_decode.sv
// ============================================================================
// opcode_class_decode: maps an opcode to its instruction class and the index
// of the final execute step of that class.
// Revision: 1.0
// ============================================================================
`default_nettype none

module opcode_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    output iclass_t           cls,
    output logic [STEP_W-1:0] last_step
);

    always_comb begin
        cls       = C_NOP;
        last_step = T2;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL: begin cls = C_ALU;    last_step = T5; end
            OP_ADDI, OP_ANDI, OP_ORI,
            OP_LDI:                  begin cls = C_IMM;    last_step = T5; end
            OP_LD:                   begin cls = C_LD;     last_step = T7; end
            OP_ST:                   begin cls = C_ST;     last_step = T7; end
            OP_MUL, OP_DIV:          begin cls = C_MULDIV; last_step = T6; end
            OP_HALT:                 begin cls = C_HALT;   last_step = T2; end
            default:                 begin cls = C_NOP;    last_step = T2; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer: hard-wired control unit stepping fetch and per-class
// execute steps, with memory-handshake stalls and halt handling.
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.master bus
);

    state_t            state, state_nx;
    logic [STEP_W-1:0] step, step_nx;
    logic              stop_pend, stop_pend_nx;
    iclass_t           cls;
    logic [STEP_W-1:0] last_step;
    logic              wait_step;
    strobes_t          strb;

    opcode_class_decode u_decode (
        .opcode    (bus.ir[31:27]),
        .cls       (cls),
        .last_step (last_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RST;
            step      <= T0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            stop_pend <= stop_pend_nx;
        end
    end

    assign wait_step = (step == T1) || (cls == C_LD && step == T6) ||
                       (cls == C_ST && step == T7);

    // A stop seen anywhere in the instruction is remembered so it takes
    // effect at retirement even if the request was only a pulse.
    always_comb begin
        state_nx     = state;
        step_nx      = step;
        stop_pend_nx = stop_pend;
        case (state)
            S_RST: begin
                state_nx     = S_RUN;
                step_nx      = T0;
                stop_pend_nx = 1'b0;
            end
            S_RUN: begin
                if (bus.stop) stop_pend_nx = 1'b1;
                if (!wait_step || bus.mem_ready) begin
                    if (step == last_step) begin
                        step_nx = T0;
                        if (cls == C_HALT || bus.stop || stop_pend)
                            state_nx = S_HALT;
                    end else begin
                        step_nx = step + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        strb = '0;
        if (state == S_RUN) begin
            case (step)
                T0: begin strb.PCout = 1'b1; strb.MARin = 1'b1; strb.IncPC = 1'b1; strb.Zin = 1'b1; end
                T1: begin strb.Zlowout = 1'b1; strb.PCin = 1'b1; strb.Read = 1'b1; strb.MDRin = 1'b1; end
                T2: begin strb.MDRout = 1'b1; strb.IRin = 1'b1; end
                default: begin
                    case (cls)
                        C_ALU: begin
                            case (step)
                                T3: begin strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1; end
                                T4: begin strb.Grc = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; end
                                T5: begin strb.Zlowout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        C_IMM, C_LD, C_ST: begin
                            case (step)
                                T3: begin strb.Grb = 1'b1; strb.Rout = 1'b1; strb.BAout = 1'b1; strb.Yin = 1'b1; end
                                T4: begin strb.Cout = 1'b1; strb.Zin = 1'b1; end
                                T5: begin
                                    strb.Zlowout = 1'b1;
                                    if (cls == C_IMM) begin strb.Gra = 1'b1; strb.Rin = 1'b1; end
                                    else              strb.MARin = 1'b1;
                                end
                                T6: begin
                                    strb.MDRin = 1'b1;
                                    if (cls == C_LD) strb.Read = 1'b1;
                                    else begin strb.Gra = 1'b1; strb.Rout = 1'b1; end
                                end
                                T7: begin
                                    if (cls == C_LD) begin strb.MDRout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
                                    else             strb.Write = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        C_MULDIV: begin
                            case (step)
                                T3: begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1; end
                                T4: begin strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; end
                                T5: begin strb.Zlowout = 1'b1; strb.LOin = 1'b1; end
                                T6: begin strb.Zhighout = 1'b1; strb.HIin = 1'b1; end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign bus.run = (state == S_RUN);
    assign {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.Cout,
            bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
            bus.Zin, bus.HIin, bus.LOin, bus.IncPC,
            bus.Read, bus.Write,
            bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
            bus.BAout} = strb;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// tb_control_sequencer: directed scoreboard bench for control_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {K_IDLE, K_F0, K_F1, K_F2, K_R3, K_R4, K_R5, K_I3, K_I4, K_L5,
                  K_L6, K_L7, K_S6, K_S7, K_M3, K_M4, K_M5, K_M6} kind_t;

    typedef struct packed {
        logic [31:0] ir;
        logic        stp;
        logic        mr;
        logic        run;
        strobes_t    s;
    } ent_t;

    localparam logic [31:0] ADD_IR = 32'h18918000;

    ent_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_ir;
    logic [22:0] obs;

    assign obs = {bus.run, bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.Cout,
                  bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
                  bus.Zin, bus.HIin, bus.LOin, bus.IncPC,
                  bus.Read, bus.Write,
                  bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout};

    function automatic strobes_t model(kind_t k);
        strobes_t e = '0;
        case (k)
            K_F0: begin e.PCout = 1'b1; e.MARin = 1'b1; e.IncPC = 1'b1; e.Zin = 1'b1; end
            K_F1: begin e.Zlowout = 1'b1; e.PCin = 1'b1; e.Read = 1'b1; e.MDRin = 1'b1; end
            K_F2: begin e.MDRout = 1'b1; e.IRin = 1'b1; end
            K_R3: begin e.Grb = 1'b1; e.Rout = 1'b1; e.Yin = 1'b1; end
            K_R4: begin e.Grc = 1'b1; e.Rout = 1'b1; e.Zin = 1'b1; end
            K_R5: begin e.Zlowout = 1'b1; e.Gra = 1'b1; e.Rin = 1'b1; end
            K_I3: begin e.Grb = 1'b1; e.Rout = 1'b1; e.BAout = 1'b1; e.Yin = 1'b1; end
            K_I4: begin e.Cout = 1'b1; e.Zin = 1'b1; end
            K_L5: begin e.Zlowout = 1'b1; e.MARin = 1'b1; end
            K_L6: begin e.Read = 1'b1; e.MDRin = 1'b1; end
            K_L7: begin e.MDRout = 1'b1; e.Gra = 1'b1; e.Rin = 1'b1; end
            K_S6: begin e.Gra = 1'b1; e.Rout = 1'b1; e.MDRin = 1'b1; end
            K_S7: begin e.Write = 1'b1; end
            K_M3: begin e.Gra = 1'b1; e.Rout = 1'b1; e.Yin = 1'b1; end
            K_M4: begin e.Grb = 1'b1; e.Rout = 1'b1; e.Zin = 1'b1; end
            K_M5: begin e.Zlowout = 1'b1; e.LOin = 1'b1; end
            K_M6: begin e.Zhighout = 1'b1; e.HIin = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Each entry: expected outputs for one cycle plus the inputs to apply
    // for the remainder of that cycle (sampled on its closing edge).
    task automatic push(kind_t k, logic mr = 1'b1, logic stp = 1'b0);
        ent_t en;
        en.ir  = cur_ir;
        en.stp = stp;
        en.mr  = mr;
        en.run = (k != K_IDLE);
        en.s   = model(k);
        sb.push_back(en);
    endtask

    task automatic drain(string tag);
        ent_t en;
        int   idx = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            en = sb.pop_front();
            checks++;
            assert (obs === {en.run, en.s}) else begin
                errors++;
                $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, {en.run, en.s});
            end
            bus.ir        = en.ir;
            bus.mem_ready = en.mr;
            bus.stop      = en.stp;
            idx++;
        end
    endtask

    task automatic check_quiet(string tag);
        checks++;
        assert (obs === 23'h0) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, 23'h0);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.ir = '0;
        bus.mem_ready = 1'b1;
        bus.stop = 1'b0;

        cur_ir = ADD_IR;
        push(K_IDLE); push(K_IDLE);
        drain("reset");
        rst = 1'b1;

        push(K_F0); push(K_F1); push(K_F2); push(K_R3); push(K_R4); push(K_R5);
        drain("add");

        cur_ir = {OP_LD, 27'h0123456};
        push(K_F0); push(K_F1); push(K_F2); push(K_I3); push(K_I4); push(K_L5);
        push(K_L6, 1'b0); push(K_L6, 1'b0); push(K_L6, 1'b0); push(K_L6, 1'b1);
        push(K_L7);
        drain("ld");

        cur_ir = {OP_ST, 27'h0654321};
        push(K_F0, 1'b0); push(K_F1); push(K_F2); push(K_I3); push(K_I4); push(K_L5);
        push(K_S6, 1'b0); push(K_S7, 1'b0); push(K_S7, 1'b0); push(K_S7, 1'b1);
        drain("st");

        cur_ir = {OP_MUL, 27'h0230000};
        push(K_F0); push(K_F1); push(K_F2); push(K_M3); push(K_M4); push(K_M5); push(K_M6);
        drain("mul");

        cur_ir = {5'd30, 27'h7ffffff};
        push(K_F0); push(K_F1); push(K_F2);
        drain("undef");

        cur_ir = {OP_ADDI, 27'h0110005};
        push(K_F0); push(K_F1); push(K_F2); push(K_I3); push(K_I4); push(K_R5);
        drain("addi");

        cur_ir = ADD_IR;
        push(K_F0); push(K_F1); push(K_F2); push(K_R3, 1'b1, 1'b1); push(K_R4); push(K_R5);
        push(K_IDLE, 1'b0); push(K_IDLE, 1'b1); push(K_IDLE, 1'b0); push(K_IDLE, 1'b1);
        drain("stop");

        rst = 1'b0;
        push(K_IDLE);
        drain("halt_rst");
        rst = 1'b1;
        push(K_F0); push(K_F1, 1'b0); push(K_F1, 1'b0);
        drain("wait_t1");
        #2 rst = 1'b0;
        #1 check_quiet("async_rst");
        @(negedge clk);
        check_quiet("rst_held");
        rst = 1'b1;
        bus.mem_ready = 1'b1;

        push(K_F0); push(K_F1); push(K_F2); push(K_R3); push(K_R4); push(K_R5);
        drain("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
